// File: rtl/jpeg_pkg.sv
// Shared JPEG marker codes and parser state encoding.
package jpeg_pkg;

    localparam logic [7:0] M_TEM   = 8'h01;
    localparam logic [7:0] M_SOF0  = 8'hC0;
    localparam logic [7:0] M_DHT   = 8'hC4;
    localparam logic [7:0] M_RST0  = 8'hD0;
    localparam logic [7:0] M_RST7  = 8'hD7;
    localparam logic [7:0] M_SOI   = 8'hD8;
    localparam logic [7:0] M_EOI   = 8'hD9;
    localparam logic [7:0] M_SOS   = 8'hDA;
    localparam logic [7:0] M_DQT   = 8'hDB;
    localparam logic [7:0] M_STUFF = 8'h00;
    localparam logic [7:0] M_FILL  = 8'hFF;

    typedef enum logic [2:0] {
        HUNT, MARK, LEN_HI, LEN_LO, SEG, SCAN, SCAN_FF
    } state_e;

    function automatic logic is_rst(input logic [7:0] b);
        return (b >= M_RST0) && (b <= M_RST7);
    endfunction

endpackage

// File: rtl/jpeg_destuff.sv
// Entropy-coded data output stage: drops held 0xFF, restores stuffed 0xFF00,
// flags RSTn markers. Outputs are registered one cycle after the byte.
module jpeg_destuff
    import jpeg_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       vld_i,
    input  logic       held_i,
    input  logic [7:0] byte_i,
    output logic       ovalid_o,
    output logic [7:0] odata_o,
    output logic       rst_marker_o,
    output logic       stuffed_o
);

    logic       emit_d;
    logic [7:0] data_d;
    logic       rstm_d;
    logic       stuff_d;

    always_comb begin
        emit_d  = 1'b0;
        data_d  = odata_o;
        rstm_d  = 1'b0;
        stuff_d = 1'b0;
        if (vld_i) begin
            if (held_i) begin
                // 0xFF was held back; a following 0x00 makes it data
                if (byte_i == M_STUFF) begin
                    emit_d  = 1'b1;
                    data_d  = M_FILL;
                    stuff_d = 1'b1;
                end
                rstm_d = is_rst(byte_i);
            end else if (byte_i != M_FILL) begin
                emit_d = 1'b1;
                data_d = byte_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovalid_o     <= 1'b0;
            odata_o      <= 8'h00;
            rst_marker_o <= 1'b0;
            stuffed_o    <= 1'b0;
        end else begin
            ovalid_o     <= emit_d;
            odata_o      <= data_d;
            rst_marker_o <= rstm_d;
            stuffed_o    <= stuff_d;
        end
    end

endmodule

// File: rtl/jpeg_stream_parser.sv
// JPEG marker walker: frame/SOF0 tracking plus de-stuffed scan output.
// Optional counters enabled with `define JPEG_PARSER_STATS_EN.
module jpeg_stream_parser
    import jpeg_pkg::*;
#(
    parameter logic [15:0] MAX_SEG_LEN = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
`ifdef JPEG_PARSER_STATS_EN
    output logic [31:0] scan_bytes,
    output logic [15:0] stuff_cnt,
`endif
    input  logic        ivalid,
    input  logic [7:0]  idata,
    output logic        ovalid,
    output logic [7:0]  odata,
    output logic        in_scan,
    output logic        frame_start,
    output logic        frame_end,
    output logic        sof_valid,
    output logic [15:0] width,
    output logic [15:0] height,
    output logic        rst_marker,
    output logic        err
);

    state_e      state_q, state_d;
    logic [7:0]  code_q, code_d;
    logic [7:0]  len_hi_q, len_hi_d;
    logic [15:0] rem_q, rem_d;
    logic [2:0]  off_q, off_d;
    logic        short_q, short_d;
    logic [15:0] sh_h_q, sh_h_d, sh_w_q, sh_w_d;
    logic [15:0] width_d, height_d;
    logic        fs_d, fe_d, sof_d, err_d;
    logic        post;
    logic [15:0] seg_len;
    logic        stuffed;

    assign seg_len = {len_hi_q, idata};
    assign in_scan = (state_q == SCAN) || (state_q == SCAN_FF);

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        len_hi_d = len_hi_q;
        rem_d    = rem_q;
        off_d    = off_q;
        short_d  = short_q;
        sh_h_d   = sh_h_q;
        sh_w_d   = sh_w_q;
        width_d  = width;
        height_d = height;
        fs_d     = 1'b0;
        fe_d     = 1'b0;
        sof_d    = 1'b0;
        err_d    = 1'b0;
        post     = 1'b0;
        if (ivalid) begin
            case (state_q)
                HUNT: if (idata == M_FILL) state_d = MARK;
                MARK: begin
                    if (idata == M_FILL) begin
                        state_d = MARK;
                    end else if (idata == M_STUFF || is_rst(idata)) begin
                        err_d   = 1'b1;
                        state_d = HUNT;
                    end else if (idata == M_SOI) begin
                        fs_d    = 1'b1;
                        state_d = HUNT;
                    end else if (idata == M_EOI) begin
                        fe_d    = 1'b1;
                        state_d = HUNT;
                    end else if (idata == M_TEM) begin
                        state_d = HUNT;
                    end else begin
                        code_d  = idata;
                        state_d = LEN_HI;
                    end
                end
                LEN_HI: begin
                    len_hi_d = idata;
                    state_d  = LEN_LO;
                end
                LEN_LO: begin
                    if (seg_len < 16'd2 || seg_len > MAX_SEG_LEN) begin
                        err_d   = 1'b1;
                        state_d = HUNT;
                    end else begin
                        rem_d   = seg_len - 16'd2;
                        off_d   = 3'd0;
                        short_d = seg_len < 16'd7;
                        if (seg_len == 16'd2) post = 1'b1;
                        else                  state_d = SEG;
                    end
                end
                SEG: begin
                    rem_d = rem_q - 16'd1;
                    if (off_q != 3'd7) off_d = off_q + 3'd1;
                    if (code_q == M_SOF0) begin
                        case (off_q)
                            3'd1: sh_h_d[15:8] = idata;
                            3'd2: sh_h_d[7:0]  = idata;
                            3'd3: sh_w_d[15:8] = idata;
                            3'd4: sh_w_d[7:0]  = idata;
                            default: ;
                        endcase
                    end
                    if (rem_q == 16'd1) post = 1'b1;
                end
                SCAN: state_d = (idata == M_FILL) ? SCAN_FF : SCAN;
                SCAN_FF: begin
                    if (idata == M_STUFF || is_rst(idata)) begin
                        state_d = SCAN;
                    end else if (idata == M_FILL) begin
                        state_d = SCAN_FF;
                    end else if (idata == M_EOI) begin
                        fe_d    = 1'b1;
                        state_d = HUNT;
                    end else if (idata == M_SOI) begin
                        fs_d    = 1'b1;
                        state_d = HUNT;
                    end else begin
                        // tables may be redefined between scans; not an error
                        code_d  = idata;
                        state_d = LEN_HI;
                    end
                end
                default: state_d = HUNT;
            endcase
            if (post) begin
                if (code_q == M_SOF0) begin
                    if (short_d) begin
                        err_d = 1'b1;
                    end else begin
                        sof_d    = 1'b1;
                        height_d = sh_h_d;
                        width_d  = sh_w_d;
                    end
                end
                state_d = (code_q == M_SOS) ? SCAN : HUNT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HUNT;
            code_q      <= 8'h00;
            len_hi_q    <= 8'h00;
            rem_q       <= 16'h0000;
            off_q       <= 3'd0;
            short_q     <= 1'b0;
            sh_h_q      <= 16'h0000;
            sh_w_q      <= 16'h0000;
            width       <= 16'h0000;
            height      <= 16'h0000;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            sof_valid   <= 1'b0;
            err         <= 1'b0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            len_hi_q    <= len_hi_d;
            rem_q       <= rem_d;
            off_q       <= off_d;
            short_q     <= short_d;
            sh_h_q      <= sh_h_d;
            sh_w_q      <= sh_w_d;
            width       <= width_d;
            height      <= height_d;
            frame_start <= fs_d;
            frame_end   <= fe_d;
            sof_valid   <= sof_d;
            err         <= err_d;
        end
    end

    jpeg_destuff u_destuff (
        .clk          (clk),
        .rst          (rst),
        .vld_i        (ivalid && in_scan),
        .held_i       (state_q == SCAN_FF),
        .byte_i       (idata),
        .ovalid_o     (ovalid),
        .odata_o      (odata),
        .rst_marker_o (rst_marker),
        .stuffed_o    (stuffed)
    );

`ifdef JPEG_PARSER_STATS_EN
    logic [31:0] bytes_q, bytes_d;
    logic [15:0] stuff_q, stuff_d;

    always_comb begin
        bytes_d = bytes_q;
        stuff_d = stuff_q;
        if (ovalid && bytes_q != 32'hFFFF_FFFF) bytes_d = bytes_q + 32'd1;
        if (stuffed && stuff_q != 16'hFFFF)     stuff_d = stuff_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bytes_q    <= 32'd0;
            stuff_q    <= 16'd0;
            scan_bytes <= 32'd0;
            stuff_cnt  <= 16'd0;
        end else begin
            bytes_q <= fs_d ? 32'd0 : bytes_d;
            stuff_q <= fs_d ? 16'd0 : stuff_d;
            if (fe_d) begin
                scan_bytes <= bytes_d;
                stuff_cnt  <= stuff_d;
            end
        end
    end
`else
    logic unused_stuffed;
    assign unused_stuffed = stuffed;
`endif

endmodule

// File: tb/tb_jpeg_stream_parser.sv
// Directed self-checking bench for jpeg_stream_parser.
module tb_jpeg_stream_parser;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ivalid = 1'b0;
    logic [7:0]  idata = 8'h00;
    logic        ovalid, in_scan, frame_start, frame_end, sof_valid, rst_marker, err;
    logic [7:0]  odata;
    logic [15:0] width, height;

    int checks = 0;
    int errors = 0;
    int n_fs, n_fe, n_sof, n_rst, n_err, stray;
    logic [7:0] oq[$];
    logic [7:0] vec[$];
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    jpeg_stream_parser dut (
        .clk(clk), .rst(rst), .ivalid(ivalid), .idata(idata),
        .ovalid(ovalid), .odata(odata), .in_scan(in_scan),
        .frame_start(frame_start), .frame_end(frame_end),
        .sof_valid(sof_valid), .width(width), .height(height),
        .rst_marker(rst_marker), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear();
        oq.delete();
        n_fs = 0; n_fe = 0; n_sof = 0; n_rst = 0; n_err = 0; stray = 0;
    endtask

    task automatic sample(input bit idle);
        if (ovalid) begin
            if (idle) stray++;
            else      oq.push_back(odata);
        end
        n_fs  += int'(frame_start);
        n_fe  += int'(frame_end);
        n_sof += int'(sof_valid);
        n_rst += int'(rst_marker);
        n_err += int'(err);
    endtask

    task automatic idle_cycle();
        ivalid = 1'b0;
        @(posedge clk); #1;
        sample(1'b1);
    endtask

    task automatic send(input logic [7:0] b);
        ivalid = 1'b1;
        idata  = b;
        @(posedge clk); #1;
        sample(1'b0);
        ivalid = 1'b0;
        idata  = 8'h00;
    endtask

    task automatic send_vec(input int gap_max);
        for (int i = 0; i < vec.size(); i++) begin
            send(vec[i]);
            if (gap_max > 0)
                for (int g = 0; g < (i % (gap_max + 1)); g++) idle_cycle();
        end
    endtask

    task automatic chk_out(input string tag);
        chk({tag, "_len"}, oq.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < oq.size(); i++)
            chk($sformatf("%s_b%0d", tag, i), {24'h0, oq[i]}, {24'h0, exp_q[i]});
    endtask

    task automatic send_sof(input logic [15:0] h, input logic [15:0] w);
        vec = '{8'hFF, 8'hC0, 8'h00, 8'h11, 8'h08, h[15:8], h[7:0], w[15:8], w[7:0],
                8'h03, 8'h01, 8'h22, 8'h00, 8'h02, 8'h11, 8'h01, 8'h03, 8'h11, 8'h01};
        send_vec(0);
    endtask

    task automatic send_sos();
        vec = '{8'hFF, 8'hDA, 8'h00, 8'h08, 8'h01, 8'h01, 8'h00, 8'h00, 8'h3F, 8'h00};
        send_vec(0);
    endtask

    initial begin
        clear();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ovalid", {31'h0, ovalid}, 0);
        chk("rst_in_scan", {31'h0, in_scan}, 0);
        chk("rst_pulses", {27'h0, frame_start, frame_end, sof_valid, rst_marker, err}, 0);
        chk("rst_width", {16'h0, width}, 0);
        chk("rst_height", {16'h0, height}, 0);
        rst = 1'b0;

        // full encoder-style frame
        clear();
        vec = '{8'hFF, 8'hD8}; send_vec(0);
        chk("f1_fs", n_fs, 1);
        vec = '{8'hFF, 8'hDB, 8'h00, 8'h05, 8'h00, 8'h01, 8'h02}; send_vec(0);
        send_sof(16'h01E0, 16'h0280);
        chk("f1_sof", n_sof, 1);
        chk("f1_height", {16'h0, height}, 32'd480);
        chk("f1_width", {16'h0, width}, 32'd640);
        vec = '{8'hFF, 8'hC4, 8'h00, 8'h04, 8'h00, 8'h01}; send_vec(0);
        chk("f1_hdr_noscan", {31'h0, in_scan}, 0);
        send_sos();
        chk("f1_in_scan", {31'h0, in_scan}, 1);
        chk("f1_hdr_noout", oq.size(), 0);
        vec = '{8'h12, 8'hFF, 8'h00, 8'h34, 8'hFF, 8'hD9}; send_vec(0);
        exp_q = '{8'h12, 8'hFF, 8'h34}; chk_out("f1_out");
        chk("f1_fe", n_fe, 1);
        chk("f1_err", n_err, 0);
        chk("f1_scan_exit", {31'h0, in_scan}, 0);

        // restart marker in scan
        clear();
        vec = '{8'hFF, 8'hD8}; send_vec(0);
        send_sos();
        vec = '{8'h56, 8'hFF, 8'hD3, 8'h78, 8'hFF, 8'hD9}; send_vec(0);
        exp_q = '{8'h56, 8'h78}; chk_out("rst_out");
        chk("rstm_cnt", n_rst, 1);
        chk("rstm_keep_w", {16'h0, width}, 32'd640);

        // length / marker errors
        clear();
        vec = '{8'hFF, 8'hDB, 8'h00, 8'h01}; send_vec(0);
        chk("len1_err", n_err, 1);
        vec = '{8'hFF, 8'hD8}; send_vec(0);
        chk("len1_recover_fs", n_fs, 1);
        clear();
        vec = '{8'hFF, 8'h00}; send_vec(0);
        chk("mark00_err", n_err, 1);
        clear();
        vec = '{8'hFF, 8'hDB, 8'h00, 8'h02, 8'hFF, 8'hD8}; send_vec(0);
        chk("len2_noerr", n_err, 0);
        chk("len2_fs", n_fs, 1);
        clear();
        vec = '{8'hFF, 8'hC0, 8'h00, 8'h05, 8'h08, 8'h00, 8'h10}; send_vec(0);
        chk("sofshort_err", n_err, 1);
        chk("sofshort_nosof", n_sof, 0);
        chk("sofshort_keep_h", {16'h0, height}, 32'd480);

        // idle gaps between scan bytes
        clear();
        vec = '{8'hFF, 8'hD8}; send_vec(0);
        send_sos();
        vec = '{8'hAA, 8'hFF, 8'h00, 8'hBB, 8'hFF, 8'hD5, 8'hCC, 8'hFF, 8'hD9};
        send_vec(5);
        exp_q = '{8'hAA, 8'hFF, 8'hBB, 8'hCC}; chk_out("gap_out");
        chk("gap_stray", stray, 0);
        chk("gap_rstm", n_rst, 1);
        chk("gap_fe", n_fe, 1);

        // reset while holding 0xFF
        clear();
        vec = '{8'hFF, 8'hD8}; send_vec(0);
        send_sos();
        vec = '{8'h11, 8'hFF}; send_vec(0);
        rst = 1'b1;
        idle_cycle();
        rst = 1'b0;
        chk("mrst_in_scan", {31'h0, in_scan}, 0);
        chk("mrst_width", {16'h0, width}, 0);
        send(8'h00);
        exp_q = '{8'h11}; chk_out("mrst_out");
        chk("mrst_stray", stray, 0);
        chk("mrst_err", n_err, 0);

        // missing EOI then new frame
        clear();
        vec = '{8'hFF, 8'hD8}; send_vec(0);
        send_sof(16'h01E0, 16'h0280);
        send_sos();
        vec = '{8'h11, 8'hFF, 8'hD8}; send_vec(0);
        chk("noeoi_fs", n_fs, 2);
        chk("noeoi_fe", n_fe, 0);
        chk("noeoi_in_scan", {31'h0, in_scan}, 0);
        chk("noeoi_keep_w", {16'h0, width}, 32'd640);
        chk("noeoi_keep_h", {16'h0, height}, 32'd480);
        send_sof(16'h0010, 16'h0020);
        chk("newsof_h", {16'h0, height}, 32'h10);
        chk("newsof_w", {16'h0, width}, 32'h20);
        exp_q = '{8'h11}; chk_out("noeoi_out");

        repeat (2) idle_cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jpeg_stream_parser.md
Name: jpeg_stream_parser

Overview:
- Receive-side counterpart of the MJPEG encoder; consumes its byte stream (valid + 8-bit byte, no backpressure).
- Walks the JPEG marker structure (SOI, marker segments, SOF0, SOS, EOI) and captures frame width/height from SOF0.
- Removes 0xFF00 byte stuffing from entropy-coded scan data and emits clean scan bytes.
- Sits between the capture byte source and a downstream Huffman/entropy decoder or a stream checker.

Parameters:
- MAX_SEG_LEN, 16'hFFFF, largest accepted segment length field; larger values flag err.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ivalid  in  1  input byte strobe
- idata  in  8  input byte
- ovalid  out  1  de-stuffed scan byte strobe
- odata  out  8  de-stuffed scan byte
- in_scan  out  1  high while in entropy-coded data
- frame_start  out  1  one-cycle pulse on SOI (FFD8)
- frame_end  out  1  one-cycle pulse on EOI (FFD9)
- sof_valid  out  1  one-cycle pulse when width/height are updated
- width  out  16  SOF0 samples per line
- height  out  16  SOF0 number of lines
- rst_marker  out  1  one-cycle pulse on RSTn (FFD0-FFD7) inside scan
- err  out  1  one-cycle pulse on protocol error

Behaviour:
- Reset:
  - All outputs 0, width/height 0, state HUNT.
  - rst asserted mid-stream discards any held byte and partial segment.
- The FSM advances only on cycles with ivalid=1; idle cycles change nothing.
- All pulse outputs and ovalid are registered, 1 cycle after the input byte that causes them.
- States:
  - HUNT: wait for 0xFF, then go to MARK; any other byte is ignored.
  - MARK: 0xFF is a fill byte, stay. 0x00 or 0xD0-0xD7 → err, back to HUNT. D8 → frame_start, HUNT. D9 → frame_end, HUNT. 01 → HUNT, no length. Any other code → latch code, go to LEN_HI.
  - LEN_HI / LEN_LO: assemble 16-bit length L, MSB first. If L<2 or L>MAX_SEG_LEN → err, HUNT. Otherwise load remaining=L-2; go to SEG, or straight to the post-segment action if remaining=0.
  - SEG: decrement remaining on each byte.
    - If code=C0, capture payload offsets 1-2 as height and 3-4 as width into shadow registers.
    - When remaining hits 0: if C0, commit shadows to height/width and pulse sof_valid; if L<7, commit nothing and pulse err instead.
    - If code=DA, go to SCAN; otherwise go to HUNT.
  - SCAN (in_scan=1): a non-FF byte is emitted immediately (ovalid, odata=byte). 0xFF → hold it, go to SCAN_FF, no output.
  - SCAN_FF:
    - 00 → emit 0xFF, return to SCAN.
    - D0-D7 → rst_marker pulse, return to SCAN, nothing emitted.
    - FF → fill; stay, nothing emitted.
    - D9 → frame_end, HUNT, in_scan=0.
    - D8 → frame_start, HUNT; this recovers from a missing EOI.
    - Any other marker → leave scan, latch code, go to LEN_HI; no err, since DHT/DQT may legally follow.
- Scan output latency is 1 cycle for normal bytes. A stuffed 0xFF is emitted 1 cycle after its 0x00 byte.
- Scan data is never emitted outside SCAN/SCAN_FF.
- Counter widths:
  - remaining is 16 bits and never wraps, because the state leaves SEG at 0.
  - The payload offset counter saturates at 7.
- width/height hold their last committed value across frames, until reset or a new SOF0.

Optional Feature:
- Macro JPEG_PARSER_STATS_EN.
- When defined, adds outputs scan_bytes[31:0] and stuff_cnt[15:0]:
  - scan_bytes counts ovalid strobes; stuff_cnt counts removed 0x00 stuff bytes.
  - Both clear on frame_start and saturate at all-ones.
  - Both are latched into visible registers on frame_end.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package jpeg_pkg:
  - Marker code constants: SOI=D8, EOI=D9, SOF0=C0, DHT=C4, DQT=DB, SOS=DA, RST0-7 range, TEM=01.
  - FSM state enum: HUNT, MARK, LEN_HI, LEN_LO, SEG, SCAN, SCAN_FF.
- One natural sub-module, jpeg_destuff: the SCAN/SCAN_FF held-byte logic, shared later by a bit reader. Everything else stays in the top.

Test Plan:
- Encoder header stream FFD8, DQT, SOF0 (len 0011, P=08, H=01E0, W=0280, Nf=03...), DHT, SOS, then scan 12 FF 00 34 FF D9 → frame_start; sof_valid with height=480, width=640; ovalid bytes 12, FF, 34 in order; frame_end; err never asserted.
- Scan 56 FF D3 78 → odata 56, then 78; rst_marker pulses once; no FF emitted.
- Segment FFDB 00 01 → err pulse, state HUNT; the following FFD8 still produces frame_start.
- Bytes with ivalid gaps of 0-5 idle cycles between every scan byte → identical odata sequence; each ovalid is exactly 1 cycle after its trigger byte.
- rst asserted while in SCAN_FF holding 0xFF → no output; in_scan=0; next byte 00 is ignored.
- Back-to-back frames with a missing EOI: scan 11 FF D8 → frame_start with no frame_end; width/height keep their previous values until the new SOF0.
